sample_frame_buffer: RTL and testbench
======================================

Name: sample_frame_buffer

Overview:
Ping-pong frame assembler upstream of the FIR low-pass stage. It accepts a valid/ready stream of 8-bit unsigned samples and packs them into N_SAMPLES-entry frames in two alternating banks. For each completed frame it presents the frame on a stable parallel array and pulses start_flg for the filter. The next frame fills into the other bank meanwhile.

Parameters:
N_SAMPLES, 256, samples per frame; power of two, >= 4
DATA_W, 8, sample width, unsigned
HOLD_CYCLES, 4, minimum cycles frame_o stays stable after a start_flg pulse before it may be replaced; 0 = no minimum
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  in_data holds a sample
in_data  in  DATA_W  sample, unsigned
in_ready  out  1  block accepts a sample this cycle
flush  in  1  synchronous; discard the partial frame
start_flg  out  1  one-cycle pulse: new frame on frame_o
frame_o  out  DATA_W x [0:N_SAMPLES-1]  unpacked array; index 0 = oldest sample of the frame
fill_level  out  $clog2(N_SAMPLES)+1  samples in the bank being filled
frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate):
  - both banks all zero; wr_bank=0; rd_bank=1; wr_idx=0; hold_cnt=0
  - start_flg=0; frame_cnt=0; fill_level=0; frame_o all zero
  - in_ready=1 once rst is released
- Accept: sample accepted on a rising edge when in_valid && in_ready && !flush. bank[wr_bank][wr_idx] <= in_data, then wr_idx++.
- in_ready = !flush && !(wr_idx==N_SAMPLES-1 && hold_cnt!=0). Only the last sample of a frame may stall. Never a combinational function of in_valid.
- Frame completion, on the edge that accepts sample N_SAMPLES-1:
  - rd_bank <= wr_bank; wr_bank toggles; wr_idx <= 0
  - hold_cnt <= HOLD_CYCLES
  - frame_cnt++
  - start_flg <= 1
- start_flg: high for exactly one cycle, starting the cycle after the completing edge. The new frame_o is valid in that same cycle.
- frame_o continuously equals bank[rd_bank]. The displayed bank is never written while displayed.
- hold_cnt decrements by 1 per cycle while nonzero and saturates at 0. A completion reloads it.
- fill_level = wr_idx; it reads 0 in the cycle start_flg is high.
- flush:
  - wr_idx <= 0; in_ready low that cycle; a sample offered with flush is dropped
  - rd_bank, frame_o, hold_cnt, frame_cnt, start_flg unaffected
  - a completion cannot coincide with flush
- in_valid gaps: no effect on ordering or contents. Gaps may lengthen a frame's fill time indefinitely.
- Back-to-back frames: no idle cycle is required between the last sample of one frame and the first of the next.
- Arithmetic: data is copied unmodified, with no scaling or sign conversion. Counters wrap silently.
- Reset mid-fill or mid-hold: everything returns to reset state. The partial frame is lost and no start_flg is emitted.

Test Plan:
1. Reset check: assert rst mid-simulation without a clock -> immediately start_flg=0, frame_cnt=0, fill_level=0, every frame_o[i]=0; in_ready=1 after release.
2. Continuous stream (defaults), in_data=i for i=0..255 with in_valid held high -> start_flg high for exactly one cycle, the cycle after sample 255 is accepted; frame_o[i]=i for all i; frame_cnt=1; fill_level=0.
3. Second frame 255-i streamed immediately after frame 1 -> frame_o stays i throughout the fill; at the second start_flg, frame_o[i]=255-i and frame_cnt=2. A third frame i^8'h5A then lands in bank 0.
4. Stall case, override N_SAMPLES=4, HOLD_CYCLES=4, continuous valid:
   - frame 1 {1,2,3,4}, then frame 2 {5,6,7,8}
   - in_ready low for exactly one cycle, before sample 8
   - frame_o stays {1,2,3,4} until the second start_flg, then {5,6,7,8}
   - no sample lost or duplicated
5. Flush: stream 100 samples, pulse flush together with a valid sample -> that sample dropped; fill_level=0; no start_flg; frame_o unchanged. The next 256 samples form one frame whose frame_o[0] is the first post-flush sample.
6. Random in_valid (about 40% duty) over 3 frames with incrementing data -> each frame_o[i] equals the expected sequence, 3 start_flg pulses, frame_cnt=3. Then assert rst after 50 samples of frame 4 -> frame_o all zero, frame_cnt=0, no start_flg.

Source files
------------

// File: rtl/sample_frame_buffer.sv
// Ping-pong frame assembler: packs a valid/ready stream of unsigned samples
// into N_SAMPLES-entry frames across two alternating banks, shows the last
// completed frame on frame_o and pulses start_flg once per completed frame.
module sample_frame_buffer #(
  parameter int N_SAMPLES   = 256,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         start_flg,
  output logic [DATA_W-1:0]            frame_o [0:N_SAMPLES-1],
  output logic [$clog2(N_SAMPLES):0]   fill_level,
  output logic [CNT_W-1:0]             frame_cnt
);

  localparam int IDX_W  = $clog2(N_SAMPLES);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

  // Two sample banks; one is filled while the other is displayed.
  logic [DATA_W-1:0] bank_q [2][N_SAMPLES];
  logic [DATA_W-1:0] bank_d [2][N_SAMPLES];

  logic              wr_bank_q,  wr_bank_d;
  logic              rd_bank_q,  rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q,   wr_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              start_flg_q, start_flg_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic ready_s;
  logic accept_s;
  logic complete_s;

  // Ready: only the last sample of a frame can stall, while the previous
  // frame is still inside its minimum display window; flush always blocks.
  always_comb begin
    ready_s    = 1'b0;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    if (flush) begin
      ready_s = 1'b0;
    end else if ((wr_idx_q == LAST_IDX) && (hold_cnt_q != HOLD_ZERO)) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
    accept_s   = in_valid && ready_s;
    complete_s = accept_s && (wr_idx_q == LAST_IDX);
  end

  // Next-state: bank write, index advance, bank swap on completion,
  // hold-window countdown and frame counting.
  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    hold_cnt_d  = hold_cnt_q;
    start_flg_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (accept_s) begin
      bank_d[wr_bank_q][wr_idx_q] = in_data;
    end else begin
      bank_d = bank_q;
    end

    if (complete_s) begin
      rd_bank_d   = wr_bank_q;
      wr_bank_d   = ~wr_bank_q;
      wr_idx_d    = {IDX_W{1'b0}};
      hold_cnt_d  = HOLD_LOAD;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
      start_flg_d = 1'b1;
    end else begin
      if (flush) begin
        wr_idx_d = {IDX_W{1'b0}};
      end else if (accept_s) begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end else begin
        wr_idx_d = wr_idx_q;
      end
      if (hold_cnt_q != HOLD_ZERO) begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end else begin
        hold_cnt_d = HOLD_ZERO;
      end
    end
  end

  // State registers with asynchronous reset to the empty, bank-0-filling state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
          bank_q[b][i] <= {DATA_W{1'b0}};
        end
      end
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      wr_idx_q    <= {IDX_W{1'b0}};
      hold_cnt_q  <= HOLD_ZERO;
      start_flg_q <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      start_flg_q <= start_flg_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Outputs: displayed bank and registered status.
  always_comb begin
    for (int i = 0; i < N_SAMPLES; i++) begin
      frame_o[i] = bank_q[rd_bank_q][i];
    end
    in_ready   = ready_s;
    start_flg  = start_flg_q;
    frame_cnt  = frame_cnt_q;
    fill_level = {1'b0, wr_idx_q};
  end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Directed bench for sample_frame_buffer: a default instance (256 samples)
// and a small instance (4 samples, hold 4) for the last-sample stall case.
module tb_sample_frame_buffer;

  logic clk;
  logic rst;

  // default instance
  logic       d_valid, d_ready, d_flush, d_start;
  logic [7:0] d_data;
  logic [7:0] d_frame [0:255];
  logic [8:0] d_fill;
  logic [15:0] d_cnt;

  // small instance
  logic       s_valid, s_ready, s_flush, s_start;
  logic [7:0] s_data;
  logic [7:0] s_frame [0:3];
  logic [2:0] s_fill;
  logic [15:0] s_cnt;

  int checks;
  int errors;
  int d_pulses;
  logic [7:0] exp_d [0:255];

  sample_frame_buffer u_dut (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_data(d_data),
    .in_ready(d_ready), .flush(d_flush), .start_flg(d_start),
    .frame_o(d_frame), .fill_level(d_fill), .frame_cnt(d_cnt)
  );

  sample_frame_buffer #(.N_SAMPLES(4), .DATA_W(8), .HOLD_CYCLES(4), .CNT_W(16)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .flush(s_flush), .start_flg(s_start),
    .frame_o(s_frame), .fill_level(s_fill), .frame_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count start pulses of the default instance, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) d_pulses <= 0;
    else if (d_start) d_pulses <= d_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame_d(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 256; i++) if (d_frame[i] !== exp_d[i]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, stalls, stall_at, starts, cyc, sent, frames, base;
    logic rdy, v;
    checks = 0; errors = 0;
    d_valid = 1'b0; d_flush = 1'b0; d_data = 8'd0;
    s_valid = 1'b0; s_flush = 1'b0; s_data = 8'd0;
    rst = 1'b1;
    #2;
    // 1. reset state
    for (int i = 0; i < 256; i++) exp_d[i] = 8'd0;
    chk("rst_start", 32'(d_start), 32'd0);
    chk("rst_cnt", 32'(d_cnt), 32'd0);
    chk("rst_fill", 32'(d_fill), 32'd0);
    chk_frame_d("rst_frame");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(d_ready), 32'd1);
    tick();

    // 4. small instance stall case
    idx = 0; stalls = 0; stall_at = 0; starts = 0; cyc = 0;
    while (idx < 8 && cyc < 40) begin
      s_valid = 1'b1;
      s_data = 8'(idx + 1);
      rdy = s_ready;
      if (!rdy) begin
        stalls++;
        stall_at = idx + 1;
        for (int k = 0; k < 4; k++) chk("s_frame_during_stall", 32'(s_frame[k]), 32'(k + 1));
      end
      tick();
      cyc++;
      if (rdy) idx++;
      if (s_start) begin
        starts++;
        for (int k = 0; k < 4; k++) chk("s_frame_at_start", 32'(s_frame[k]), 32'(4 * (starts - 1) + k + 1));
      end
    end
    s_valid = 1'b0;
    chk("s_all_sent", 32'(idx), 32'd8);
    chk("s_stalls", 32'(stalls), 32'd1);
    chk("s_stall_at", 32'(stall_at), 32'd8);
    chk("s_starts", 32'(starts), 32'd2);
    chk("s_cnt", 32'(s_cnt), 32'd2);

    // 2. continuous frame 1: i
    for (int i = 0; i < 256; i++) begin
      d_valid = 1'b1; d_data = 8'(i);
      tick();
      if (i == 99) chk("t2_fill_mid", 32'(d_fill), 32'd100);
      if (i == 254) chk("t2_no_early_start", 32'(d_start), 32'd0);
    end
    for (int i = 0; i < 256; i++) exp_d[i] = 8'(i);
    chk("t2_start", 32'(d_start), 32'd1);
    chk("t2_cnt", 32'(d_cnt), 32'd1);
    chk("t2_fill", 32'(d_fill), 32'd0);
    chk_frame_d("t2_frame");

    // 3. frame 2: 255-i, back to back
    for (int j = 0; j < 256; j++) begin
      d_data = 8'(255 - j);
      tick();
      if (j == 0) chk("t3_start_one_cycle", 32'(d_start), 32'd0);
      if (j == 0 || j == 254) chk_frame_d("t3_frame_held");
    end
    for (int i = 0; i < 256; i++) exp_d[i] = 8'(255 - i);
    chk("t3_start2", 32'(d_start), 32'd1);
    chk("t3_cnt2", 32'(d_cnt), 32'd2);
    chk_frame_d("t3_frame2");
    // frame 3: i ^ 5A
    for (int j = 0; j < 256; j++) begin
      d_data = 8'(j) ^ 8'h5A;
      tick();
      if (j == 128) chk_frame_d("t3_frame2_held");
    end
    for (int i = 0; i < 256; i++) exp_d[i] = 8'(i) ^ 8'h5A;
    chk("t3_cnt3", 32'(d_cnt), 32'd3);
    chk_frame_d("t3_frame3");
    d_valid = 1'b0;
    tick();
    chk("t3_start_low", 32'(d_start), 32'd0);
    chk("t3_pulses", 32'(d_pulses), 32'd3);

    // 5. flush
    for (int i = 0; i < 100; i++) begin
      d_valid = 1'b1; d_data = 8'(i + 17);
      tick();
    end
    chk("t5_fill100", 32'(d_fill), 32'd100);
    d_flush = 1'b1; d_data = 8'hEE;
    #1;
    chk("t5_ready_low", 32'(d_ready), 32'd0);
    base = d_pulses;
    tick();
    d_flush = 1'b0; d_valid = 1'b0;
    chk("t5_fill0", 32'(d_fill), 32'd0);
    chk("t5_no_start", 32'(d_start), 32'd0);
    chk("t5_cnt", 32'(d_cnt), 32'd3);
    chk_frame_d("t5_frame_kept");
    tick();
    chk("t5_no_pulse", 32'(d_pulses), 32'(base));
    for (int i = 0; i < 256; i++) begin
      d_valid = 1'b1; d_data = 8'(200 + i);
      tick();
    end
    d_valid = 1'b0;
    for (int i = 0; i < 256; i++) exp_d[i] = 8'(200 + i);
    chk("t5_start", 32'(d_start), 32'd1);
    chk("t5_cnt4", 32'(d_cnt), 32'd4);
    chk("t5_first", 32'(d_frame[0]), 32'd200);
    chk_frame_d("t5_frame");

    // 6. random valid gaps over 3 frames, after a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    tick();
    chk("t6_cnt_reset", 32'(d_cnt), 32'd0);
    base = d_pulses;
    sent = 0; cyc = 0; frames = 0;
    while (sent < 768 && cyc < 6000) begin
      v = ($urandom_range(0, 99) < 40);
      d_valid = v;
      d_data = 8'(sent + sent / 256);
      rdy = d_ready;
      tick();
      cyc++;
      if (v && rdy) sent++;
      if (d_start) begin
        frames++;
        for (int i = 0; i < 256; i++) exp_d[i] = 8'(i + frames - 1);
        chk_frame_d("t6_frame");
      end
    end
    d_valid = 1'b0;
    chk("t6_sent", 32'(sent), 32'd768);
    chk("t6_frames", 32'(frames), 32'd3);
    chk("t6_cnt", 32'(d_cnt), 32'd3);
    tick();
    chk("t6_pulses", 32'(d_pulses - base), 32'd3);
    for (int i = 0; i < 50; i++) begin
      d_valid = 1'b1; d_data = 8'(i + 1);
      tick();
    end
    d_valid = 1'b0;
    chk("t6_fill50", 32'(d_fill), 32'd50);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) exp_d[i] = 8'd0;
    chk_frame_d("t6_rst_frame");
    chk("t6_rst_cnt", 32'(d_cnt), 32'd0);
    chk("t6_rst_fill", 32'(d_fill), 32'd0);
    chk("t6_rst_start", 32'(d_start), 32'd0);
    rst = 1'b0;
    base = d_pulses;
    repeat (5) tick();
    chk("t6_no_pulse", 32'(d_pulses), 32'(base));
    chk("t6_ready", 32'(d_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
